// File: rtl/test_monitor.sv
// Test monitor: watches error, finish and heartbeat strobes from a design under
// test and latches a single verdict (PASS / FAIL / TIMEOUT / HANG).
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   clear      - synchronous restart, same effect as reset at the next edge
//   err_i      - NUM_ERR error strobes (level or pulse)
//   fin_i      - NUM_FIN finish strobes (level or pulse)
//   hb_i       - heartbeat pulse from the design under test
//   done       - high once a verdict is latched
//   result     - 0 RUNNING, 1 PASS, 2 FAIL, 3 TIMEOUT, 4 HANG
//   first_err  - lowest error channel index on the first error edge
//   fail_cycle - cycle count sampled on the first error edge
//   cc         - cycle counter, saturating, frozen once done
module test_monitor #(
  parameter int unsigned NUM_ERR        = 2,
  parameter int unsigned NUM_FIN        = 2,
  parameter bit          FIN_ALL        = 1'b0,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'h10000,
  parameter logic [31:0] HANG_CYCLES    = 32'd0,
  parameter int unsigned POLL_LOG2      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [NUM_ERR-1:0] err_i,
  input  logic [NUM_FIN-1:0] fin_i,
  input  logic               hb_i,
  output logic               done,
  output logic [2:0]         result,
  output logic [3:0]         first_err,
  output logic [31:0]        fail_cycle,
  output logic [31:0]        cc
);

  typedef enum logic [0:0] {StRun, StDone} state_e;

  localparam logic [2:0] ResRunning = 3'd0;
  localparam logic [2:0] ResPass    = 3'd1;
  localparam logic [2:0] ResFail    = 3'd2;
  localparam logic [2:0] ResTimeout = 3'd3;
  localparam logic [2:0] ResHang    = 3'd4;

  // Low POLL_LOG2 bits of cc; an all-zero mask makes every edge a poll edge.
  localparam logic [31:0] PollMask = (32'd1 << POLL_LOG2) - 32'd1;

  state_e             state_q, state_d;
  logic [2:0]         result_q, result_d;
  logic [3:0]         first_err_q, first_err_d;
  logic [31:0]        fail_cycle_q, fail_cycle_d;
  logic [31:0]        cc_q, cc_d;
  logic [31:0]        idle_q, idle_d;
  logic [NUM_FIN-1:0] fin_q, fin_d;
  logic               err_flag_q, err_flag_d;
  logic               timeout_q, timeout_d;
  logic               hang_q, hang_d;

  logic       fin_flag;
  logic       poll;
  logic [3:0] low_idx;

  always_comb begin
    fin_flag = FIN_ALL ? (&fin_q) : (|fin_q);
    poll     = ((cc_q & PollMask) == 32'd0);

    low_idx = 4'd0;
    for (int i = int'(NUM_ERR) - 1; i >= 0; i--) begin
      if (err_i[i]) low_idx = 4'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    first_err_d  = first_err_q;
    fail_cycle_d = fail_cycle_q;
    cc_d         = cc_q;
    idle_d       = idle_q;
    fin_d        = fin_q;
    err_flag_d   = err_flag_q;
    timeout_d    = timeout_q;
    hang_d       = hang_q;

    if (clear) begin
      state_d      = StRun;
      result_d     = ResRunning;
      first_err_d  = 4'd0;
      fail_cycle_d = 32'd0;
      cc_d         = 32'd0;
      idle_d       = 32'd0;
      fin_d        = '0;
      err_flag_d   = 1'b0;
      timeout_d    = 1'b0;
      hang_d       = 1'b0;
    end else if (state_q == StRun) begin
      cc_d = (cc_q == 32'hFFFF_FFFF) ? cc_q : cc_q + 32'd1;

      if (|err_i) begin
        err_flag_d = 1'b1;
        if (!err_flag_q) begin
          first_err_d  = low_idx;
          fail_cycle_d = cc_q;
        end
      end

      fin_d = fin_q | fin_i;

      if (cc_q > TIMEOUT_CYCLES) timeout_d = 1'b1;

      if (hb_i) begin
        idle_d = 32'd0;
      end else if (idle_q != 32'hFFFF_FFFF) begin
        idle_d = idle_q + 32'd1;
      end

      if ((HANG_CYCLES != 32'd0) && (idle_q > HANG_CYCLES)) hang_d = 1'b1;

      // Verdict looks only at registered flags, so same-edge strobes wait a poll.
      if (poll && (err_flag_q || hang_q || fin_flag || timeout_q)) begin
        state_d = StDone;
        if (err_flag_q) begin
          result_d = ResFail;
        end else if (hang_q) begin
          result_d = ResHang;
        end else if (fin_flag) begin
          result_d = ResPass;
        end else begin
          result_d = ResTimeout;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRun;
      result_q     <= ResRunning;
      first_err_q  <= 4'd0;
      fail_cycle_q <= 32'd0;
      cc_q         <= 32'd0;
      idle_q       <= 32'd0;
      fin_q        <= '0;
      err_flag_q   <= 1'b0;
      timeout_q    <= 1'b0;
      hang_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      first_err_q  <= first_err_d;
      fail_cycle_q <= fail_cycle_d;
      cc_q         <= cc_d;
      idle_q       <= idle_d;
      fin_q        <= fin_d;
      err_flag_q   <= err_flag_d;
      timeout_q    <= timeout_d;
      hang_q       <= hang_d;
    end
  end

  assign done       = (state_q == StDone);
  assign result     = result_q;
  assign first_err  = first_err_q;
  assign fail_cycle = fail_cycle_q;
  assign cc         = cc_q;

endmodule
